// File: rtl/fifo_shift_pkg.sv
// Shared definitions for the shift-FIFO line-delay sequencer.
//   state_e          : controller state encoding (2 bits)
//   DATA_WIDTH_DEF   : default sample width
//   DEPTH_WIDTH_DEF  : default FIFO address width
//   DEPTH_MAX        : usable FIFO depth at the default address width
//   FLUSH_CYCLES_DEF : default number of cycles fifo_rst is held at frame start
package fifo_shift_pkg;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int DEPTH_WIDTH_DEF  = 10;
    localparam int DEPTH_MAX        = 2**DEPTH_WIDTH_DEF - 1;
    localparam int FLUSH_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_FILL   = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_shift_ctrl_if.sv
// Bus between the line-delay controller and the synchronous shift FIFO.
//   rst      : FIFO reset (controller -> FIFO)
//   wr_en    : write strobe, wr_data : write sample
//   rd_en    : read strobe, rd_data : read sample, valid one cycle after rd_en
//   wr_full  : FIFO full flag, rd_empty : FIFO empty flag
// master = controller side, slave = FIFO side.
interface fifo_shift_ctrl_if
    import fifo_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  rst;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_full;
    logic                  rd_empty;

    modport master (
        output rst, wr_en, wr_data, rd_en,
        input  rd_data, wr_full, rd_empty
    );

    modport slave (
        input  rst, wr_en, wr_data, rd_en,
        output rd_data, wr_full, rd_empty
    );
endinterface

// File: rtl/fifo_shift_rdpipe.sv
// Two-stage read pipeline: stage 0 tracks that FIFO read data is arriving,
// stage 1 registers it as the delayed output sample.
//   clk, rst    : clock, synchronous active-high reset
//   rd_en_i     : FIFO read issued this cycle
//   kill_i      : discard every read still in flight
//   rd_data_i   : FIFO read data (valid the cycle after rd_en_i)
//   out_valid_o : delayed sample strobe (2 cycles after rd_en_i)
//   out_data_o  : delayed sample
module fifo_shift_rdpipe
    import fifo_shift_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en_i,
    input  logic                  kill_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);
    localparam int STAGES = 2;

    logic [STAGES-1:0]     vld_pipe_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            data_q     <= '0;
        end else begin
            // kill flushes both stages, so a read issued the cycle before
            // kill (data still on rd_data) never reaches the output
            vld_pipe_q <= kill_i ? '0 : {vld_pipe_q[STAGES-2:0], rd_en_i};
            if (vld_pipe_q[0] && !kill_i)
                data_q <= rd_data_i;
        end
    end

    assign out_valid_o = vld_pipe_q[STAGES-1];
    assign out_data_o  = data_q;
endmodule

// File: rtl/fifo_shift_ctrl.sv
// Line-delay sequencer around a synchronous shift FIFO. After a frame start
// the FIFO is flushed, filled with len samples, then every accepted sample
// writes one entry and reads one back, giving a fixed len-sample delay.
//   clk, rst      : clock, synchronous active-high reset
//   sof_i         : start of frame; the same-cycle sample is dropped
//   line_len_i    : delay in samples, captured on sof_i (clamped 1..2**DEPTH_WIDTH-1)
//   in_valid_i    : input sample strobe, in_data_i : input sample
//   out_valid_o   : delayed sample strobe, out_data_o : delayed sample
//   fill_level_o  : samples currently held in the FIFO
//   busy_o        : flushing or filling
//   err_ovf_o     : sticky, write issued while FIFO full
//   err_unf_o     : sticky, read issued while FIFO empty
//   drop_o        : one-cycle pulse per sample discarded while flushing
//   fifo          : FIFO bus (master side)
module fifo_shift_ctrl
    import fifo_shift_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int DEPTH_WIDTH  = DEPTH_WIDTH_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sof_i,
    input  logic [DEPTH_WIDTH:0]   line_len_i,
    input  logic                   in_valid_i,
    input  logic [DATA_WIDTH-1:0]  in_data_i,
    output logic                   out_valid_o,
    output logic [DATA_WIDTH-1:0]  out_data_o,
    output logic [DEPTH_WIDTH:0]   fill_level_o,
    output logic                   busy_o,
    output logic                   err_ovf_o,
    output logic                   err_unf_o,
    output logic                   drop_o,
    fifo_shift_ctrl_if.master      fifo
);
    localparam int                   LW         = DEPTH_WIDTH + 1;
    localparam int                   CW         = $clog2(FLUSH_CYCLES);
    localparam logic [LW-1:0]        LEN_MAX    = LW'((1 << DEPTH_WIDTH) - 1);
    localparam logic [CW-1:0]        FLUSH_LAST = CW'(FLUSH_CYCLES - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [LW-1:0] len_q, len_cap, fill_q, fill_inc;
    logic          fifo_rst_q, busy_q, drop_q, ovf_q, unf_q;
    logic          wr_en, rd_en;

    always_comb begin
        len_cap = line_len_i;
        if (line_len_i == '0)
            len_cap = LW'(1);
        else if (line_len_i > LEN_MAX)
            len_cap = LEN_MAX;
    end

    // The sof-cycle sample belongs to the new frame and is dropped, so no
    // FIFO traffic is issued in that cycle.
    assign wr_en    = in_valid_i && !sof_i && (state_q == ST_FILL || state_q == ST_STREAM);
    assign rd_en    = in_valid_i && !sof_i && (state_q == ST_STREAM);
    assign fill_inc = fill_q + LW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= LW'(1);
            fill_q     <= '0;
            fifo_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            drop_q <= in_valid_i && (sof_i || state_q == ST_FLUSH);
            if (wr_en && fifo.wr_full)
                ovf_q <= 1'b1;
            if (rd_en && fifo.rd_empty)
                unf_q <= 1'b1;

            if (sof_i) begin
                // sof from any state restarts the frame
                state_q    <= ST_FLUSH;
                cnt_q      <= '0;
                len_q      <= len_cap;
                fill_q     <= '0;
                fifo_rst_q <= 1'b1;
                busy_q     <= 1'b1;
                ovf_q      <= 1'b0;
                unf_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_FLUSH: begin
                        if (cnt_q == FLUSH_LAST) begin
                            state_q    <= ST_FILL;
                            fifo_rst_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    ST_FILL: begin
                        if (in_valid_i) begin
                            fill_q <= fill_inc;
                            if (fill_inc == len_q) begin
                                state_q <= ST_STREAM;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ST_STREAM: ;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign fifo.rst     = fifo_rst_q;
    assign fifo.wr_en   = wr_en;
    assign fifo.wr_data = in_data_i;
    assign fifo.rd_en   = rd_en;

    assign fill_level_o = fill_q;
    assign busy_o       = busy_q;
    assign err_ovf_o    = ovf_q;
    assign err_unf_o    = unf_q;
    assign drop_o       = drop_q;

    fifo_shift_rdpipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rdpipe (
        .clk         (clk),
        .rst         (rst),
        .rd_en_i     (rd_en),
        .kill_i      (sof_i),
        .rd_data_i   (fifo.rd_data),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o)
    );
endmodule

// File: tb/tb_fifo_shift_ctrl.sv
// Directed bench for fifo_shift_ctrl with a behavioural FIFO on the bus and a
// delay-line scoreboard of expected outputs stamped with their due cycle.
module tb_fifo_shift_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        sof, in_valid;
    logic [10:0] line_len;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [10:0] fill_level;
    logic        busy, err_ovf, err_unf, drop;
    logic        force_full, force_empty;

    fifo_shift_ctrl_if #(.DATA_WIDTH(8)) ifc ();

    fifo_shift_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sof_i        (sof),
        .line_len_i   (line_len),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .fill_level_o (fill_level),
        .busy_o       (busy),
        .err_ovf_o    (err_ovf),
        .err_unf_o    (err_unf),
        .drop_o       (drop),
        .fifo         (ifc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural shift FIFO: read pops oldest, write appends, rst empties
    logic [7:0] fq[$];
    int         fcnt = 0;
    initial ifc.rd_data = '0;
    always @(posedge clk) begin
        if (ifc.rst) begin
            fq.delete();
        end else begin
            if (ifc.rd_en && !ifc.rd_empty) ifc.rd_data <= fq.pop_front();
            if (ifc.wr_en && !ifc.wr_full) fq.push_back(ifc.wr_data);
        end
        fcnt <= fq.size();
    end
    assign ifc.wr_full  = force_full || (fcnt > 1023);
    assign ifc.rd_empty = force_empty || (fcnt == 0);

    typedef struct { logic [7:0] data; int due; } sb_t;
    sb_t        sb[$];
    bit         drop_at[int];
    logic [7:0] hist[$];
    int         ncmp = 0, nfail = 0;
    int         tb_len, flush_left;
    bit         in_frame, sb_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // one input cycle; the bench's own delay-line model predicts outputs
    task automatic step(input logic s, input logic v, input logic [7:0] d, input logic [10:0] ll);
        sof = s; in_valid = v; in_data = d; line_len = ll;
        if (s) begin
            if (v) drop_at[cyc + 1] = 1'b1;
            in_frame   = 1'b1;
            flush_left = 4;
            hist.delete();
            tb_len = (ll == 0) ? 1 : (ll > 1023) ? 1023 : int'(ll);
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
        end else if (flush_left > 0) begin
            if (v) drop_at[cyc + 1] = 1'b1;
            flush_left--;
        end else if (in_frame && v) begin
            hist.push_back(d);
            if (sb_on && hist.size() > tb_len)
                sb.push_back('{data: hist[hist.size()-1-tb_len], due: cyc + 2});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00, 11'd0);
    endtask

    logic exp_v;
    sb_t  e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("drop", drop, drop_at.exists(cyc));
            if (sb_on) begin
                exp_v = sb.size() > 0 && sb[0].due == cyc;
                chk("out_valid", out_valid, exp_v);
                if (exp_v) begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sof = 0; in_valid = 0; in_data = 0; line_len = 0;
        force_full = 0; force_empty = 0;
        sb_on = 1; in_frame = 0; flush_left = 0; tb_len = 1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_unf", err_unf, 0);
        chk("rst_drop", drop, 0);
        chk("rst_fifo_rst", ifc.rst, 1);
        chk("rst_wr_en", ifc.wr_en, 0);
        chk("rst_rd_en", ifc.rd_en, 0);
        rst = 1'b0;

        // 1: len 4, sof sample dropped, fill with 01..04, stream 05..0B
        step(1, 1, 8'h00, 11'd4);
        chk("t1_busy_flush", busy, 1);
        chk("t1_fifo_rst", ifc.rst, 1);
        idle(4);
        for (int i = 1; i <= 11; i++) begin
            step(0, 1, 8'(i), 11'd0);
            if (i == 3) begin chk("t1_busy_3", busy, 1); chk("t1_fill_3", fill_level, 3); end
            if (i == 4) begin chk("t1_busy_4", busy, 0); chk("t1_fill_4", fill_level, 4); end
        end
        idle(3);
        chk("t1_fill_hold", fill_level, 4);
        chk("t1_sb_drained", sb.size(), 0);

        // 2a: line_len 0 behaves as 1
        step(1, 0, 8'h00, 11'd0);
        idle(4);
        step(0, 1, 8'hA0, 11'd0);
        chk("t2a_busy", busy, 0);
        chk("t2a_fill", fill_level, 1);
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(8'hA0 + i), 11'd0);
        idle(3);
        chk("t2a_sb_drained", sb.size(), 0);

        // 2b: line_len 2000 clamps to 1023
        step(1, 0, 8'h00, 11'd2000);
        idle(4);
        for (int i = 0; i < 1022; i++) step(0, 1, 8'(i), 11'd0);
        chk("t2b_busy_1022", busy, 1);
        chk("t2b_fill_1022", fill_level, 1022);
        step(0, 1, 8'hFE, 11'd0);
        chk("t2b_busy_1023", busy, 0);
        chk("t2b_fill_1023", fill_level, 1023);
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h55 + i), 11'd0);
        idle(3);
        chk("t2b_fill_hold", fill_level, 1023);
        chk("t2b_sb_drained", sb.size(), 0);

        // 3: streaming with in_valid on alternate cycles
        step(1, 0, 8'h00, 11'd3);
        idle(4);
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h30 + i), 11'd0);
        for (int i = 0; i < 10; i++) step(0, (i % 2) == 0, 8'(8'h40 + i), 11'd0);
        idle(3);
        chk("t3_ovf", err_ovf, 0);
        chk("t3_unf", err_unf, 0);
        chk("t3_sb_drained", sb.size(), 0);

        // 4: underflow, then sof mid-stream kills the in-flight read
        step(1, 0, 8'h00, 11'd2);
        idle(4);
        for (int i = 0; i < 6; i++) step(0, 1, 8'(8'h60 + i), 11'd0);
        idle(2);
        chk("t4_sb_drained", sb.size(), 0);
        sb_on = 0;
        force_empty = 1;
        step(0, 1, 8'h66, 11'd0);
        force_empty = 0;
        chk("t4_unf_set", err_unf, 1);
        step(0, 1, 8'h67, 11'd0);
        chk("t4_out_before_sof", out_valid, 1);
        step(1, 1, 8'h68, 11'd3);
        chk("t4_out_killed", out_valid, 0);
        chk("t4_unf_clr", err_unf, 0);
        chk("t4_ovf_clr", err_ovf, 0);
        chk("t4_fill_clr", fill_level, 0);
        chk("t4_fifo_rst_1", ifc.rst, 1);
        sb_on = 1;
        for (int i = 2; i <= 4; i++) begin
            idle(1);
            chk($sformatf("t4_fifo_rst_%0d", i), ifc.rst, 1);
        end
        idle(1);
        chk("t4_fifo_rst_off", ifc.rst, 0);
        chk("t4_busy_fill", busy, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h70 + i), 11'd0);
        idle(3);
        chk("t4_sb_after", sb.size(), 0);

        // 5: overflow during FILL is sticky until the next sof
        sb_on = 0;
        step(1, 0, 8'h00, 11'd4);
        idle(4);
        step(0, 1, 8'h80, 11'd0);
        force_full = 1;
        step(0, 1, 8'h81, 11'd0);
        force_full = 0;
        chk("t5_ovf_set", err_ovf, 1);
        chk("t5_unf_clear", err_unf, 0);
        step(0, 1, 8'h82, 11'd0);
        idle(2);
        chk("t5_ovf_sticky", err_ovf, 1);

        // 6: samples during FLUSH are dropped, one pulse each
        sb_on = 1;
        step(1, 1, 8'h90, 11'd2);
        chk("t6_ovf_clr", err_ovf, 0);
        chk("t6_fill_sof", fill_level, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 8'(8'hA0 + i), 11'd0);
            chk($sformatf("t6_fill_flush_%0d", i), fill_level, 0);
        end
        for (int i = 1; i <= 4; i++) step(0, 1, 8'(8'h90 + i), 11'd0);
        idle(3);
        chk("t6_fill_end", fill_level, 2);
        chk("t6_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/fifo_shift_ctrl.md
Name: fifo_shift_ctrl

Overview:
Sequencer that runs the 8-bit synchronous shift FIFO (fifo_shift) as a programmable line-delay element for the pixel pipeline.
- Fills the FIFO with line_len samples at frame start, then streams: each accepted input sample writes one entry and reads one entry, so the FIFO level stays constant at line_len.
- Output stream is the input delayed by exactly line_len samples, used to build vertical taps.
- Resets the FIFO between frames and flags overflow/underflow.

Parameters:
DATA_WIDTH, 8, sample width; equals the FIFO write/read width
DEPTH_WIDTH, 10, FIFO address width; usable depth 2**DEPTH_WIDTH-1 = 1023
FLUSH_CYCLES, 4, cycles fifo_rst is held high at frame start (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sof  in  1  start-of-frame pulse; qualifies the same-cycle in_valid sample as the first of the frame
line_len  in  DEPTH_WIDTH+1  delay in samples; sampled on sof
in_valid  in  1  input sample strobe
in_data  in  DATA_WIDTH  input sample
out_valid  out  1  delayed sample strobe
out_data  out  DATA_WIDTH  delayed sample
fifo_rst  out  1  to FIFO rst
fifo_wr_en  out  1  to FIFO wr_en
fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
fifo_rd_en  out  1  to FIFO rd_en
fifo_rd_data  in  DATA_WIDTH  from FIFO rd_data; valid 1 cycle after rd_en
fifo_full  in  1  from FIFO wr_full
fifo_empty  in  1  from FIFO rd_empty
fill_level  out  DEPTH_WIDTH+1  samples currently held (controller count)
busy  out  1  high in FLUSH or FILL
err_ovf  out  1  sticky: write attempted while fifo_full
err_unf  out  1  sticky: read attempted while fifo_empty
drop  out  1  one-cycle pulse: in_valid discarded during FLUSH

Behaviour:
Reset (rst=1 at posedge): state IDLE. All outputs 0, except fifo_rst=1. fill_level=0, len_q=1.

line_len capture on sof:
- 0 -> 1.
- > 2**DEPTH_WIDTH-1 -> 1023.
- Result is registered as len_q.

States:
- IDLE: in_valid ignored.
  - sof -> FLUSH.
- FLUSH:
  - fifo_rst=1 for FLUSH_CYCLES cycles (counter), then -> FILL.
  - fill_level cleared.
  - in_valid during FLUSH -> drop pulse next cycle; the sample is lost. This includes the sof sample.
- FILL:
  - in_valid -> fifo_wr_en=1, fifo_wr_data=in_data (combinational, same cycle), fill_level+1.
  - When fill_level reaches len_q (after the increment) -> STREAM.
  - No reads.
- STREAM:
  - in_valid -> fifo_wr_en=1 and fifo_rd_en=1 in the same cycle. fill_level is unchanged.
  - rd_en at cycle t -> fifo_rd_data valid at t+1 -> out_data/out_valid registered at t+2.
  - Total latency from input strobe to out_valid = 2 cycles, carrying the sample written len_q strobes earlier.
- sof in FILL or STREAM: abort and go to FLUSH. Any read in flight is discarded: out_valid is suppressed for reads issued in the cycle of sof or the cycle before.

Errors:
- err_ovf set if fifo_wr_en && fifo_full.
- err_unf set if fifo_rd_en && fifo_empty.
- Both clear only on rst or on entry to FLUSH.
- The write/read is still issued; the FIFO ignores it.

Simultaneous/boundary cases:
- sof and in_valid together in IDLE -> FLUSH; the sample is dropped.
- len_q=1: the first in_valid in FILL moves to STREAM; the next sample reads it back.
- len_q=1023: FIFO never full in STREAM because each read pairs with a write.
- in_valid gaps are allowed in every state; there is no backpressure.

Arithmetic: fill_level and len_q are DEPTH_WIDTH+1 bits, unsigned; there is no wrap.

Decomposition:
Package fifo_shift_pkg:
- state encoding (IDLE, FLUSH, FILL, STREAM; 2 bits)
- DEPTH_MAX = 2**DEPTH_WIDTH-1
- FLUSH_CYCLES default

The read-pipeline is natural as one sub-module, fifo_shift_rdpipe: 2-stage valid/data register with a kill input. Everything else stays flat.

Test Plan:
1. rst, then sof with line_len=4, then 12 samples 0x00..0x0B one per cycle -> drop on the sof sample, busy low after 4 writes; out_data = 0x01..0x07 (wait, see note) — the 4 samples after the drop (0x01..0x04) fill the FIFO; out_data 0x01..0x07 follows samples 0x05..0x0B, each 2 cycles after its input strobe; fill_level holds 4.
2. line_len=0 -> behaves as 1: out_data equals the previous accepted sample.
   line_len=2000 -> len_q=1023.
3. STREAM with in_valid toggling every other cycle -> out_valid toggles with the same pattern, 2 cycles later; no errors.
4. sof mid-STREAM -> fifo_rst high 4 cycles; no out_valid from the reads killed by the sof; fill_level=0; err flags cleared.
5. Force fifo_full=1 during a FILL write -> err_ovf=1, sticky until the next sof.
   Force fifo_empty=1 during a STREAM read -> err_unf=1.
6. in_valid during FLUSH -> drop=1 for 1 cycle per sample; fill_level unchanged.
